// File: rtl/seq_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed/unsigned, divide-by-zero flag.
// Optional SEQ_DIV_ZERO_FAST_EN: a zero divisor skips the iteration and finishes after one clock.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_prem;
    logic [WIDTH-1:0]   r_work_q;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_dividend_orig;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_zero;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;

    logic               w_accept;
    logic               w_last;
    logic               w_dividend_neg;
    logic               w_divisor_neg;
    logic [WIDTH-1:0]   w_dividend_abs;
    logic [WIDTH-1:0]   w_divisor_abs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_trial_neg;

    assign w_accept       = (r_state == S_IDLE) && start;
    assign w_last         = (r_count == CNT_W'(WIDTH - 1));
    assign w_dividend_neg = is_signed && dividend[WIDTH-1];
    assign w_divisor_neg  = is_signed && divisor[WIDTH-1];
    assign w_dividend_abs = w_dividend_neg ? -dividend : dividend;
    assign w_divisor_abs  = w_divisor_neg  ? -divisor  : divisor;

    // partial_rem < divisor always holds, so the shifted value fits WIDTH+1 bits and
    // the MSB of the WIDTH+1-bit difference is a reliable "negative" flag.
    assign w_shift     = {r_prem, r_work_q[WIDTH-1]};
    assign w_diff      = w_shift - {1'b0, r_divisor};
    assign w_trial_neg = w_diff[WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef SEQ_DIV_ZERO_FAST_EN
                    w_next = (divisor == '0) ? S_FIX : S_RUN;
`else
                    w_next = S_RUN;
`endif
                end
            end
            S_RUN:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every state element uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count         <= '0;
            r_prem          <= '0;
            r_work_q        <= '0;
            r_divisor       <= '0;
            r_dividend_orig <= '0;
            r_q_neg         <= 1'b0;
            r_r_neg         <= 1'b0;
            r_zero          <= 1'b0;
            r_done          <= 1'b0;
            r_dbz           <= 1'b0;
            r_quotient      <= '0;
            r_remainder     <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (w_accept) begin
                r_count         <= '0;
                r_prem          <= '0;
                r_work_q        <= w_dividend_abs;
                r_divisor       <= w_divisor_abs;
                r_dividend_orig <= dividend;
                r_q_neg         <= w_dividend_neg ^ w_divisor_neg;
                r_r_neg         <= w_dividend_neg;
                r_zero          <= (divisor == '0);
            end else if (r_state == S_RUN) begin
                r_count  <= r_count + CNT_W'(1);
                r_prem   <= w_trial_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_work_q <= {r_work_q[WIDTH-2:0], ~w_trial_neg};
            end else if (r_state == S_FIX) begin
                r_dbz <= r_zero;
                if (r_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= r_dividend_orig;
                end else begin
                    // most-negative / -1 wraps naturally: -(2^(W-1)) is itself on W bits
                    r_quotient  <= r_q_neg ? -r_work_q : r_work_q;
                    r_remainder <= r_r_neg ? -r_prem   : r_prem;
                end
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: vector table, random model checks, handshake and reset sequences.
module tb_seq_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef SEQ_DIV_ZERO_FAST_EN
        return (b == '0) ? 1 : W + 1;
`else
        return W + 1;
`endif
    endfunction

    // Independent reference built from the simulator's own arithmetic.
    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a; e.z = 1'b1;
        end else if (!sgn) begin
            e.q = a / b; e.r = a % b; e.z = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = '0; e.z = 1'b0;
        end else begin
            e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.z = 1'b0;
        end
        return e;
    endfunction

    // Waits for done with a bound; elapsed counts edges already passed since the accepting edge.
    task automatic wait_done(input string tag, input int elapsed, input int exp_lat);
        int   lat = elapsed;
        bit   seen = 0;
        bit   busy_ok = 1;
        bit   hold_ok = 1;
        exp_t e;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1;
            else begin
                if (!busy) busy_ok = 0;
                if (quotient !== last_q || remainder !== last_r) hold_ok = 0;
            end
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " busy_during_run"}, 64'(busy_ok), 64'd1);
        check({tag, " outputs_held"}, 64'(hold_ok), 64'd1);
        if (seen) begin
            check({tag, " latency"}, 64'(lat), 64'(exp_lat));
            check({tag, " busy_at_done"}, 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check({tag, " scoreboard_nonempty"}, 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check({tag, " quotient"}, 64'(quotient), 64'(e.q));
                check({tag, " remainder"}, 64'(remainder), 64'(e.r));
                check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.z));
                last_q = e.q;
                last_r = e.r;
            end
        end
    endtask

    // Drives start on a falling edge; a call right after wait_done lands in the done cycle.
    task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        check({tag, " done_low_after_accept"}, 64'(done), 64'd0);
        wait_done(tag, 0, exp_latency(b));
    endtask

    vec_t vecs[12];

    initial begin
        exp_t e;
        bit   seen;

        vecs[0]  = '{1'b0, 32'd17,         32'd5,          32'd3,          32'd2,          1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0000_0001,  1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0000,  1'b0};
        vecs[4]  = '{1'b0, 32'h1234_5678,  32'h0000_0000,  32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0000,  32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
        vecs[6]  = '{1'b0, 32'hFFFF_FFF9,  32'h0000_0002,  32'h7FFF_FFFC,  32'h0000_0001,  1'b0};
        vecs[7]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  1'b0};
        vecs[9]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
        vecs[10] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'h0000_0001,  32'h8000_0000,  32'h0000_0000,  1'b0};

        clr = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset remainder", 64'(remainder), 64'd0);
        check("reset div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 12; i++) begin
            e = '{vecs[i].q, vecs[i].r, vecs[i].z};
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, e);
        end

        for (int i = 0; i < 10; i++) begin
            logic         sgn;
            logic [W-1:0] a;
            logic [W-1:0] b;
            sgn = i[0];
            a = $urandom;
            b = W'($urandom_range(1, 5000));
            if (sgn && i[1]) b = -b;
            run_op($sformatf("rnd%0d", i), sgn, a, b, model(sgn, a, b));
        end

        // second start while busy is ignored
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        sb.push_back('{32'd14, 32'd2, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore_start", 5, W + 1);

        // reset mid-operation aborts without a done pulse
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 clr = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort quotient", 64'(quotient), 64'd0);
        check("abort remainder", 64'(remainder), 64'd0);
        check("abort div_by_zero", 64'(div_by_zero), 64'd0);
        last_q = '0; last_r = '0;
        @(negedge clk);
        clr = 1'b0;
        seen = 0;
        repeat (W + 8) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        check("abort no_done", 64'(seen), 64'd0);

        run_op("after_abort", 1'b0, 32'd9, 32'd3, '{32'd3, 32'd0, 1'b0});

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle restoring divider. It is the clocked, parametrised successor to the combinational 32-bit divide unit in the ALU.
- Computes one quotient bit per clock, supports signed and unsigned operation, and reports divide-by-zero.
- Uses a start/busy/done handshake so the control unit can stall on DIV.
- Results feed the HI (remainder) and LO (quotient) registers.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits; minimum 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- clr  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request; sampled only while idle.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; captured with the operands.
- dividend  input  WIDTH  dividend, captured on an accepted start.
- divisor  input  WIDTH  divisor, captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when results become valid.
- quotient  output  WIDTH  registered quotient (LO).
- remainder  output  WIDTH  registered remainder (HI).
- div_by_zero  output  1  registered flag: the last operation had divisor == 0.

Behaviour:
- Reset (clr high, asynchronous):
  - State goes to IDLE.
  - busy, done, div_by_zero, quotient, remainder and all internal registers clear to 0.
  - A reset mid-operation aborts it and produces no done pulse.
- States:
  - IDLE: start=1 captures the operands and is_signed, then moves to RUN with count=0.
    - If is_signed=1, the absolute values of both operands are stored, plus the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
  - RUN: one restoring step per clock.
    - Shift {partial_rem, work_q} left by 1.
    - Trial-subtract the divisor from partial_rem, using WIDTH+1 bits so no borrow is lost.
    - Non-negative result: keep it and set q bit = 1. Negative result: restore and set q bit = 0.
    - After WIDTH steps (count == WIDTH-1 on the step edge), move to FIX.
  - FIX: apply sign correction, load quotient/remainder, set done=1 for one cycle, return to IDLE.
- Timing:
  - start accepted at edge 0 gives busy=1 after edge 0.
  - busy=0 and done=1 after edge WIDTH+1, so latency is WIDTH+1 clocks from the accepting edge.
  - done is high for exactly one cycle.
- Outputs hold their values until the next FIX or reset. They do not change during RUN.
- start while busy=1 is ignored; no queueing.
- start in the same cycle as done=1 is accepted, since the state is already IDLE.
- Signed results:
  - The quotient truncates toward zero and the remainder takes the dividend's sign.
  - Negation is two's complement on WIDTH bits.
- Overflow, signed most-negative / -1: quotient = most-negative value (wraps), remainder = 0, div_by_zero = 0. No separate flag.
- Divide by zero, either mode:
  - quotient = all ones, remainder = original dividend (unmodified, signed or not), div_by_zero = 1.
  - The result is forced in FIX, independent of the iteration result.
- is_signed=0 treats all operands as unsigned, with no sign handling.

Optional Feature:
- Macro: SEQ_DIV_ZERO_FAST_EN.
- Defined:
  - If divisor == 0 on an accepted start, IDLE goes directly to FIX and skips RUN.
  - done is asserted after edge 1.
  - The divide-by-zero result values are as above.
  - All other operations keep the full WIDTH+1 latency.
- Not defined: a zero divisor takes the full WIDTH+1 latency with the same forced result.

Test Plan:
1. Unsigned 17 / 5, is_signed=0, WIDTH=32, start at edge 0:
   - busy high during edges 1-32.
   - done high for one cycle after edge 33.
   - quotient=3, remainder=2, div_by_zero=0.
2. Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) gives quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
3. Signed 7 / -2 gives quotient=0xFFFFFFFD, remainder=1.
4. Signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0, div_by_zero=0.
5. Divide 0x12345678 / 0 gives quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
   - done after edge 33 without SEQ_DIV_ZERO_FAST_EN.
   - done after edge 1 with it.
6. Reset and handshake:
   - Start 100/7, pulse start again at edge 5 with 9/3: the second start is ignored and the result is 14 r 2.
   - Restart and assert clr at edge 10: busy=0 immediately, outputs cleared, no done pulse.
   - A subsequent 9/3 completes normally with quotient 3, remainder 0.
